rs232_avm_responder: RTL and testbench

Avalon-MM responder that implements the RS232 register map the RSA wrapper polls: RX data at byte address 0, TX data at 4, STATUS at 8 (bit 7 RX ready, bit 6 TX ready). Incoming key/ciphertext bytes arrive on a byte stream and are buffered in a small RX FIFO. Bytes written to TX are serialized 8N1 on `uart_txd`. The block is the peripheral end of the wrapper's bus and makes the wrapper testable and deployable without the vendor UART IP.

---
 rtl/rs232_avm_responder.sv | 195 +++++++++++++++++++
 tb/tb_rs232_avm_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_responder.sv
// Avalon-MM RS232 register responder: RX byte FIFO, 8N1 TX serializer, status/sticky error bits.
// Optional feature macro: RS232_LOOPBACK_EN (TX bytes are also pushed into the RX FIFO).
module rs232_avm_responder #(
  parameter int RX_DEPTH     = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avm_address,
  input  logic        avm_read,
  output logic [31:0] avm_readdata,
  input  logic        avm_write,
  input  logic [31:0] avm_writedata,
  output logic        avm_waitrequest,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        uart_txd
);

  localparam int AW   = $clog2(RX_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(RX_DEPTH);

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  bus_state_t bus_state, bus_next;
  tx_state_t  tx_state, tx_next;

  logic            req_read, req_write, pop_pending;
  logic [4:0]      req_addr;
  logic [7:0]      req_wdata;
  logic [7:0]      mem [RX_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic            fifo_empty, fifo_full;
  logic            tx_ovr, rx_ovf;
  logic [7:0]      tx_byte, tx_shift;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   clk_cnt;
  logic            bit_done, tx_idle;
  logic            commit, do_pop, tx_wr, tx_accept, tx_drop, status_clr;
  logic            push, ovf_set;
  logic [7:0]      push_data;
  logic [31:0]     status_word, rd_mux;
  logic            unused_bits;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == FULL_CNT);
  assign tx_idle     = (tx_state == TX_IDLE);
  assign bit_done    = (clk_cnt == BIT_LAST);
  assign status_word = {22'b0, rx_ovf, tx_ovr, ~fifo_empty, tx_idle, 6'b0};

  // Side effects of a transaction are all committed on the edge that ends ACK.
  assign commit     = (bus_state == BUS_ACK);
  assign do_pop     = commit & pop_pending;
  assign tx_wr      = commit & req_write & (req_addr == 5'd4);
  assign tx_accept  = tx_wr & tx_idle;
  assign tx_drop    = tx_wr & ~tx_idle;
  assign status_clr = commit & req_read & (req_addr == 5'd8);

`ifdef RS232_LOOPBACK_EN
  assign push        = tx_accept & ~fifo_full;
  assign push_data   = req_wdata;
  assign ovf_set     = tx_accept & fifo_full;
  assign rx_ready    = 1'b0;
  assign unused_bits = ^{avm_writedata[31:8], rx_data, rx_valid};
`else
  assign push        = rx_valid & ~fifo_full;
  assign push_data   = rx_data;
  assign ovf_set     = rx_valid & fifo_full;
  assign rx_ready    = ~fifo_full;
  assign unused_bits = ^avm_writedata[31:8];
`endif

  always_comb begin
    rd_mux = '0;
    case (avm_address)
      5'd0:    rd_mux = fifo_empty ? 32'd0 : {24'b0, mem[rd_ptr]};
      5'd4:    rd_mux = {24'b0, tx_byte};
      5'd8:    rd_mux = status_word;
      default: rd_mux = '0;
    endcase
  end

  // Bus handshake: waitrequest is low only in ACK; a request held in IDLE is captured once.
  always_comb begin
    bus_next        = bus_state;
    avm_waitrequest = 1'b1;
    case (bus_state)
      BUS_IDLE: if (avm_read | avm_write) bus_next = BUS_ACK;
      BUS_ACK: begin
        avm_waitrequest = 1'b0;
        bus_next        = BUS_IDLE;
      end
      default: bus_next = BUS_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      bus_state    <= BUS_IDLE;
      req_read     <= 1'b0;
      req_write    <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      pop_pending  <= 1'b0;
      avm_readdata <= '0;
    end else begin
      bus_state <= bus_next;
      if (bus_state == BUS_IDLE && (avm_read | avm_write)) begin
        req_read     <= avm_read;
        req_write    <= avm_write & ~avm_read;
        req_addr     <= avm_address;
        req_wdata    <= avm_writedata[7:0];
        pop_pending  <= avm_read & (avm_address == 5'd0) & ~fifo_empty;
        avm_readdata <= avm_read ? rd_mux : 32'd0;
      end
    end
  end

  always_ff @(posedge avm_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovr <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A set event in the same cycle as the STATUS-read clear wins.
      if (tx_drop)         tx_ovr <= 1'b1;
      else if (status_clr) tx_ovr <= 1'b0;
      if (ovf_set)         rx_ovf <= 1'b1;
      else if (status_clr) rx_ovf <= 1'b0;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_next = TX_START;
      TX_START: if (bit_done) tx_next = TX_DATA;
      TX_DATA:  if (bit_done && bit_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (bit_done) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      tx_state <= TX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      tx_shift <= '0;
      tx_byte  <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || bit_done) clk_cnt <= '0;
      else                                 clk_cnt <= clk_cnt + 1'b1;
      if (tx_accept) begin
        tx_shift <= req_wdata;
        tx_byte  <= req_wdata;
        bit_idx  <= '0;
      end else if (tx_state == TX_DATA && bit_done) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        bit_idx  <= bit_idx + 1'b1;
      end
    end
  end

  // Line level decoded from state so an asynchronous reset forces idle-high at once.
  always_comb begin
    uart_txd = 1'b1;
    case (tx_state)
      TX_START: uart_txd = 1'b0;
      TX_DATA:  uart_txd = tx_shift[0];
      default:  uart_txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rs232_avm_responder.sv
// Directed self-checking bench for rs232_avm_responder (RX_DEPTH=4, CLKS_PER_BIT=4).
module tb_rs232_avm_responder;

  logic        clk;
  logic        rst_n;
  logic [4:0]  address;
  logic        rd;
  logic [31:0] readdata;
  logic        wr;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        txd;

  int tests = 0;
  int fails = 0;

`ifdef RS232_LOOPBACK_EN
  localparam logic [31:0] LB_B7  = 32'h80;
  localparam logic        RDY_EXP = 1'b0;
`else
  localparam logic [31:0] LB_B7  = 32'h0;
  localparam logic        RDY_EXP = 1'b1;
`endif

  rs232_avm_responder #(.RX_DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .avm_clk(clk),
    .avm_rst_n(rst_n),
    .avm_address(address),
    .avm_read(rd),
    .avm_readdata(readdata),
    .avm_write(wr),
    .avm_writedata(writedata),
    .avm_waitrequest(waitrequest),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .uart_txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds the request until the ACK cycle; returns while still inside ACK.
  task automatic bus_xfer(input logic is_rd, input logic [4:0] a, input logic [31:0] wd,
                          output logic [31:0] rdata, output int waits);
    logic done;
    done  = 1'b0;
    waits = 0;
    rdata = 32'hxxxx_xxxx;
    address = a; writedata = wd; rd = is_rd; wr = ~is_rd;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (!waitrequest) begin
        rdata = readdata;
        done  = 1'b1;
      end else begin
        waits++;
      end
    end
    rd = 1'b0; wr = 1'b0;
    if (!done) check("bus_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic bus_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int w;
    bus_xfer(1'b1, a, 32'h0, d, w);
    check(tag, d, exp);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] d;
    int w;
    bus_xfer(1'b0, a, wd, d, w);
  endtask

  task automatic push(input logic [7:0] d);
    rx_data = d; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b96, b11;
    int w;
    rst_n = 1'b0; address = '0; rd = 1'b0; wr = 1'b0; writedata = '0;
    rx_data = '0; rx_valid = 1'b0;
    b96 = 8'h96;
    b11 = 8'h11;

    // Reset state
    #2;
    check("rst_waitreq", {31'b0, waitrequest}, 32'd1);
    check("rst_readdata", readdata, 32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, {31'b0, RDY_EXP});
    check("rst_txd", {31'b0, txd}, 32'd1);
    do_reset();
    check("idle_waitreq", {31'b0, waitrequest}, 32'd1);
    bus_xfer(1'b1, 5'd8, 32'h0, d, w);
    check("status_rst", d, 32'h40);
    check("status_rst_waits", w, 0);
    check("txd_idle", {31'b0, txd}, 32'd1);

`ifndef RS232_LOOPBACK_EN
    // Two pushes, two pops, then empty
    push(8'hA5);
    push(8'h3C);
    bus_read("rx_pop0", 5'd0, 32'hA5);
    bus_read("rx_pop1", 5'd0, 32'h3C);
    bus_read("status_empty", 5'd8, 32'h40);
    bus_read("rx_empty_read", 5'd0, 32'h0);
    bus_read("status_empty2", 5'd8, 32'h40);

    // Fill to overflow with rx_valid held
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'(i + 1);
      @(posedge clk); #1;
      if (i == 2) check("rx_ready_3", {31'b0, rx_ready}, 32'd1);
      if (i == 3) check("rx_ready_full", {31'b0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;
    bus_read("status_ovf", 5'd8, 32'h2C0);
    bus_read("status_ovf_clr", 5'd8, 32'h0C0);
    bus_read("full_pop0", 5'd0, 32'h01);
    check("rx_ready_in_ack", {31'b0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    check("rx_ready_after_pop", {31'b0, rx_ready}, 32'd1);
    bus_read("full_pop1", 5'd0, 32'h02);
    bus_read("full_pop2", 5'd0, 32'h03);
    bus_read("full_pop3", 5'd0, 32'h04);
    bus_read("status_drained", 5'd8, 32'h40);

    // Push and pop on the same edge after pointer wrap
    push(8'h10);
    push(8'h20);
    rx_data = 8'h30; rx_valid = 1'b1;
    bus_read("pp_pop0", 5'd0, 32'h10);
    rx_data = 8'h40;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    bus_read("pp_pop1", 5'd0, 32'h20);
    bus_read("pp_pop2", 5'd0, 32'h30);
    bus_read("pp_pop3", 5'd0, 32'h40);
    bus_read("pp_empty", 5'd0, 32'h0);
`else
    // Loopback: TX byte appears in RX FIFO, rx_ready held low
    rx_valid = 1'b1; rx_data = 8'hEE;
    bus_write(5'd4, 32'h5A);
    check("lb_rx_ready0", {31'b0, rx_ready}, 32'd0);
    bus_read("lb_pop", 5'd0, 32'h5A);
    check("lb_rx_ready1", {31'b0, rx_ready}, 32'd0);
    bus_read("lb_status", 5'd8, 32'h0);
    rx_valid = 1'b0;
`endif

    // 0x96 frame, each bit 4 cycles
    do_reset();
    bus_write(5'd4, 32'hFFFF_FF96);
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (b == 0)      check("tx96_start", {31'b0, txd}, 32'd0);
        else if (b == 9) check("tx96_stop", {31'b0, txd}, 32'd1);
        else             check("tx96_data", {31'b0, txd}, {31'b0, b96[b-1]});
      end
    end
    bus_read("tx96_busy_end", 5'd8, LB_B7);
    bus_read("tx96_idle", 5'd8, 32'h40 | LB_B7);

    // Overrun: second write inside the frame is dropped
    do_reset();
    bus_write(5'd4, 32'h11);
    bus_write(5'd4, 32'h22);
    bus_read("tx_byte_reg", 5'd4, 32'h11);
    bus_read("status_ovr", 5'd8, 32'h100 | LB_B7);
    check("tx11_bit0", {31'b0, txd}, {31'b0, b11[0]});
    for (int k = 1; k < 8; k++) begin
      repeat (4) @(posedge clk);
      #1;
      check("tx11_data", {31'b0, txd}, {31'b0, b11[k]});
    end
    repeat (4) @(posedge clk);
    #1;
    check("tx11_stop", {31'b0, txd}, 32'd1);
    bus_read("status_ovr_clr", 5'd8, LB_B7);
    repeat (3) @(posedge clk);
    #1;
    bus_read("tx11_idle", 5'd8, 32'h40 | LB_B7);

    // Asynchronous reset mid-frame
    do_reset();
`ifndef RS232_LOOPBACK_EN
    push(8'h77);
`endif
    bus_write(5'd4, 32'hF0);
    repeat (6) @(posedge clk);
    #1;
    check("mid_txd_low", {31'b0, txd}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_txd", {31'b0, txd}, 32'd1);
    check("mid_rst_waitreq", {31'b0, waitrequest}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus_read("mid_rst_status", 5'd8, 32'h40);
    bus_read("bad_addr", 5'd12, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
